// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int UART_DATA_W = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side AXI-stream bundle of the transmit arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  import uart_pkg::*;

  // Every link is valid/ready: a byte moves when valid and ready are both high on a clock edge.
  logic [UART_DATA_W*N_REQ-1:0] s_axis_tdata_i;
  logic [N_REQ-1:0]             s_axis_tvalid_i;
  logic [N_REQ-1:0]             s_axis_tlast_i;
  logic [N_REQ-1:0]             s_axis_tready_o;
  logic [UART_DATA_W-1:0]       m_axis_tdata_o;
  logic                         m_axis_tvalid_o;
  logic                         m_axis_tlast_o;
  logic                         m_axis_tready_i;

  modport slave (
    input  s_axis_tdata_i, s_axis_tvalid_i, s_axis_tlast_i, m_axis_tready_i,
    output s_axis_tready_o, m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o
  );

  modport master (
    output s_axis_tdata_i, s_axis_tvalid_i, s_axis_tlast_i, m_axis_tready_i,
    input  s_axis_tready_o, m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above last_ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_ptr_i,
  output logic [N_REQ-1:0]         win_o,
  output logic [$clog2(N_REQ)-1:0] win_idx_o,
  output logic                     found_o
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    found_o   = 1'b0;
    cand      = '0;
    // Offset 1..N_REQ so the previous winner is considered last.
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((int'(last_ptr_i) + i) % N_REQ);
      if (!found_o && req_i[cand]) begin
        found_o     = 1'b1;
        win_idx_o   = cand;
        win_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART AXI-stream input among N_REQ byte sources,
// holding each grant for a whole message (tlast) or MAX_BURST bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  uart_tx_arbiter_if.slave     bus,
  output logic [N_REQ-1:0]     grant_o,
  output logic                 busy_o,
  output arb_state_t           state_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [N_REQ-1:0]       pick_win;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;
  logic [UART_DATA_W-1:0] owner_data;
  logic                   in_grant;
  logic                   owner_valid;
  logic                   owner_last;
  logic                   m_valid;
  logic                   m_last;
  logic                   hs;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i      (bus.s_axis_tvalid_i),
    .last_ptr_i (last_ptr_q),
    .win_o      (pick_win),
    .win_idx_o  (pick_idx),
    .found_o    (pick_found)
  );

  // grant_q is one-hot in GRANT and zero in IDLE, so an AND-OR mux suffices.
  always_comb begin
    owner_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q[k]) begin
        owner_data = owner_data | bus.s_axis_tdata_i[k*UART_DATA_W +: UART_DATA_W];
      end
    end
  end

  assign in_grant    = (state_q == GRANT);
  assign owner_valid = |(grant_q & bus.s_axis_tvalid_i);
  assign owner_last  = |(grant_q & bus.s_axis_tlast_i);
  assign m_valid     = in_grant & owner_valid;
  assign m_last      = in_grant & (owner_last | (beat_cnt_q == BEAT_LAST));
  assign hs          = m_valid & bus.m_axis_tready_i;

  assign bus.m_axis_tdata_o  = owner_data;
  assign bus.m_axis_tvalid_o = m_valid;
  assign bus.m_axis_tlast_o  = m_last;
  assign bus.s_axis_tready_o = in_grant ? (grant_q & {N_REQ{bus.m_axis_tready_i}}) : '0;

  assign grant_o = grant_q;
  assign busy_o  = in_grant;
  assign state_o = state_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    last_ptr_d = last_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d    = pick_win;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (hs) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (m_last) begin
            last_ptr_d = owner_q;
            grant_d    = '0;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      last_ptr_q <= IDX_W'(N_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      last_ptr_q <= last_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed multi-cycle sequences and
// randomized traffic against a message-level reference model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int MB = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();
  logic [N-1:0] grant_o;
  logic         busy_o;
  arb_state_t   state_o;

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .bus     (bus),
    .grant_o (grant_o),
    .busy_o  (busy_o),
    .state_o (state_o)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- stimulus state ----------------
  logic [8:0]   src_q [N][$];   // {tlast, byte} per requester
  logic [N-1:0] en;
  int           mready_mode;    // 0: always ready, 1: random, 2: never ready
  bit           model_push;
  logic [7:0]   exp_q [$];

  // reference model: current owner (-1 idle), previous winner, bytes in grant
  int m_owner;
  int m_last;
  int m_cnt;

  typedef struct packed {
    logic [N-1:0]   vld;
    logic [N-1:0]   lst;
    logic [8*N-1:0] dat;
    logic           mr;
    logic [N-1:0]   gr;
    logic           mv;
    logic [7:0]     md;
    logic           ml;
    logic [N-1:0]   sr;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] lst, input logic [31:0] dat,
                              input logic mr, input logic [3:0] gr, input logic mv,
                              input logic [7:0] md, input logic ml, input logic [3:0] sr);
    vec_t v;
    v.vld = vld; v.lst = lst; v.dat = dat; v.mr = mr;
    v.gr = gr; v.mv = mv; v.md = md; v.ml = ml; v.sr = sr;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_zero();
    bus.s_axis_tdata_i  = '0;
    bus.s_axis_tvalid_i = '0;
    bus.s_axis_tlast_i  = '0;
    bus.m_axis_tready_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    check("rst_outputs_zero",
          {grant_o, busy_o, bus.m_axis_tvalid_o, bus.m_axis_tlast_o, bus.s_axis_tready_o}, '0);
    repeat (2) @(posedge clk);
    for (int k = 0; k < N; k++) src_q[k].delete();
    exp_q.delete();
    en = '0;
    mready_mode = 0;
    drive_zero();
    m_owner = -1;
    m_last  = N - 1;
    m_cnt   = 0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  // One clock: drive at negedge, check outputs against the model, advance sources and model.
  task automatic step();
    logic [N-1:0]   vld, lst, e_gr, e_sr;
    logic [8*N-1:0] dat;
    logic           mr, e_mv, e_ml, e_hs;
    logic [7:0]     e_md;
    int             g;
    bit             found;
    @(negedge clk);
    vld = '0; lst = '0; dat = '0;
    for (int k = 0; k < N; k++) begin
      if (en[k] && src_q[k].size() > 0) begin
        vld[k]         = 1'b1;
        lst[k]         = src_q[k][0][8];
        dat[k*8 +: 8]  = src_q[k][0][7:0];
      end
    end
    case (mready_mode)
      1:       mr = ($urandom_range(0, 3) != 0);
      2:       mr = 1'b0;
      default: mr = 1'b1;
    endcase
    bus.s_axis_tvalid_i = vld;
    bus.s_axis_tlast_i  = lst;
    bus.s_axis_tdata_i  = dat;
    bus.m_axis_tready_i = mr;
    #1;
    e_gr = '0; e_sr = '0; e_mv = 1'b0; e_ml = 1'b0; e_md = '0; e_hs = 1'b0;
    if (m_owner >= 0) begin
      g        = m_owner;
      e_gr[g]  = 1'b1;
      e_mv     = vld[g];
      e_md     = dat[g*8 +: 8];
      e_ml     = lst[g] || (m_cnt == MB - 1);
      e_sr[g]  = mr;
      e_hs     = vld[g] && mr;
    end
    check("cycle_outputs",
          {grant_o, busy_o, (state_o == GRANT), bus.m_axis_tvalid_o, bus.m_axis_tlast_o,
           bus.s_axis_tready_o, (bus.m_axis_tvalid_o ? bus.m_axis_tdata_o : 8'h00)},
          {e_gr, (m_owner >= 0), (m_owner >= 0), e_mv, e_ml, e_sr, (e_mv ? e_md : 8'h00)});
    // scoreboard
    if (e_hs && model_push) exp_q.push_back(e_md);
    if (bus.m_axis_tvalid_o && bus.m_axis_tready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected: got byte %0h expected none", bus.m_axis_tdata_o);
      end else begin
        check("beat_data", bus.m_axis_tdata_o, exp_q.pop_front());
      end
    end
    for (int k = 0; k < N; k++) begin
      if (bus.s_axis_tready_o[k] && vld[k]) void'(src_q[k].pop_front());
    end
    // model advance
    if (m_owner < 0) begin
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (m_last + i) % N;
        if (!found && vld[c]) begin
          found   = 1'b1;
          m_owner = c;
        end
      end
      m_cnt = 0;
    end else if (e_hs) begin
      m_cnt++;
      if (e_ml) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic run_until_empty(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- test body ----------------
  initial begin
    drive_zero();
    en = '0;
    mready_mode = 0;
    model_push = 1'b0;
    m_owner = -1; m_last = N - 1; m_cnt = 0;

    // vector table: two 3-byte messages, then a 5-cycle UART stall mid-message
    vecs.push_back(mk(4'b0101, 4'b0000, 32'h0061_0041, 1, 4'b0000, 0, 8'h00, 0, 4'b0000));
    vecs.push_back(mk(4'b0101, 4'b0000, 32'h0061_0041, 1, 4'b0001, 1, 8'h41, 0, 4'b0001));
    vecs.push_back(mk(4'b0101, 4'b0000, 32'h0061_0042, 1, 4'b0001, 1, 8'h42, 0, 4'b0001));
    vecs.push_back(mk(4'b0101, 4'b0001, 32'h0061_0043, 1, 4'b0001, 1, 8'h43, 1, 4'b0001));
    vecs.push_back(mk(4'b0100, 4'b0000, 32'h0061_0000, 1, 4'b0000, 0, 8'h00, 0, 4'b0000));
    vecs.push_back(mk(4'b0100, 4'b0000, 32'h0061_0000, 1, 4'b0100, 1, 8'h61, 0, 4'b0100));
    vecs.push_back(mk(4'b0100, 4'b0000, 32'h0062_0000, 1, 4'b0100, 1, 8'h62, 0, 4'b0100));
    vecs.push_back(mk(4'b0100, 4'b0100, 32'h0063_0000, 1, 4'b0100, 1, 8'h63, 1, 4'b0100));
    vecs.push_back(mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 8'h00, 0, 4'b0000));
    vecs.push_back(mk(4'b0010, 4'b0000, 32'h0000_A000, 1, 4'b0000, 0, 8'h00, 0, 4'b0000));
    vecs.push_back(mk(4'b0010, 4'b0000, 32'h0000_A000, 1, 4'b0010, 1, 8'hA0, 0, 4'b0010));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(4'b0010, 4'b0000, 32'h0000_A100, 0, 4'b0010, 1, 8'hA1, 0, 4'b0000));
    vecs.push_back(mk(4'b0010, 4'b0000, 32'h0000_A100, 1, 4'b0010, 1, 8'hA1, 0, 4'b0010));
    vecs.push_back(mk(4'b0010, 4'b0010, 32'h0000_A200, 1, 4'b0010, 1, 8'hA2, 1, 4'b0010));
    vecs.push_back(mk(4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 8'h00, 0, 4'b0000));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.s_axis_tvalid_i = vecs[i].vld;
      bus.s_axis_tlast_i  = vecs[i].lst;
      bus.s_axis_tdata_i  = vecs[i].dat;
      bus.m_axis_tready_i = vecs[i].mr;
      #1;
      check($sformatf("vec%0d", i),
            {grant_o, bus.m_axis_tvalid_o, bus.m_axis_tlast_o, bus.s_axis_tready_o,
             (bus.m_axis_tvalid_o ? bus.m_axis_tdata_o : 8'h00)},
            {vecs[i].gr, vecs[i].mv, vecs[i].ml, vecs[i].sr, (vecs[i].mv ? vecs[i].md : 8'h00)});
    end

    // burst limit: requester 1 streams 40 bytes without tlast, requester 3 has a 2-byte message
    do_reset();
    model_push = 1'b0;
    for (int n = 0; n < 40; n++) src_q[1].push_back({1'b0, 8'(8'h10 + n)});
    src_q[3].push_back({1'b0, 8'hC0});
    src_q[3].push_back({1'b1, 8'hC1});
    for (int n = 0; n < 16; n++) exp_q.push_back(8'(8'h10 + n));
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hC1);
    for (int n = 16; n < 32; n++) exp_q.push_back(8'(8'h10 + n));
    en = 4'b1010;
    run_until_empty("burst", 200);

    // all four requesters continuously valid with 1-byte messages: strictly cyclic order
    do_reset();
    for (int k = 0; k < N; k++)
      for (int n = 0; n < 3; n++) src_q[k].push_back({1'b1, 8'((k << 4) | n)});
    for (int n = 0; n < 3; n++)
      for (int k = 0; k < N; k++) exp_q.push_back(8'((k << 4) | n));
    en = 4'b1111;
    run_until_empty("round_robin", 200);

    // owner drops tvalid for 10 cycles while requester 2 waits
    do_reset();
    for (int n = 0; n < 4; n++) src_q[0].push_back({(n == 3), 8'(8'h50 + n)});
    src_q[2].push_back({1'b0, 8'h70});
    src_q[2].push_back({1'b1, 8'h71});
    for (int n = 0; n < 4; n++) exp_q.push_back(8'(8'h50 + n));
    exp_q.push_back(8'h70);
    exp_q.push_back(8'h71);
    en = 4'b0101;
    repeat (3) step();
    en = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_grant", grant_o, 4'b0001);
      check("hold_no_ready2", bus.s_axis_tready_o[2], 1'b0);
    end
    en = 4'b0101;
    run_until_empty("owner_drop", 100);

    // reset between byte 2 and byte 3, then requester 0 must win first
    do_reset();
    model_push = 1'b1;
    for (int n = 0; n < 5; n++) src_q[2].push_back({(n == 4), 8'(8'h80 + n)});
    en = 4'b0100;
    repeat (3) step();
    do_reset();
    model_push = 1'b1;
    for (int k = 0; k < 3; k++) src_q[k].push_back({1'b1, 8'(8'h90 + k)});
    en = 4'b0111;
    repeat (2) step();
    check("rst_first_winner", grant_o, 4'b0001);
    repeat (8) step();
    check("after_rst_sent", src_q[0].size() + src_q[1].size() + src_q[2].size(), 0);

    // randomized traffic against the model
    do_reset();
    model_push = 1'b1;
    mready_mode = 1;
    for (int k = 0; k < N; k++) begin
      for (int m = 0; m < 8; m++) begin
        int len;
        bit has_last;
        len = $urandom_range(1, 24);
        has_last = ($urandom_range(0, 3) != 0);
        for (int n = 0; n < len; n++)
          src_q[k].push_back({(has_last && n == len - 1), 8'($urandom_range(0, 255))});
      end
    end
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) en[k] = ($urandom_range(0, 9) < 8);
      step();
    end
    check("random_exp_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit AXI-stream slave port between `N_REQ` byte-stream requesters (e.g. console, debug dump, status reporter). A grant is held for a whole message, ending on `tlast` or after `MAX_BURST` bytes, so bytes from different sources never interleave on the serial line. Sits directly in front of the UART's `s_axis_*` input, with a zero-latency data path once granted.

## Interface
- `N_REQ`, 4: number of requester ports, 2..8
- `MAX_BURST`, 16: maximum bytes per grant, power of two, 2..256
- `clk_i` in 1: single clock domain
- `rst_i` in 1: reset, asynchronous, active-high
- `s_axis_tdata_i` in 8*N_REQ: requester bytes, requester k at bits [8k+7:8k]
- `s_axis_tvalid_i` in N_REQ: per-requester valid
- `s_axis_tlast_i` in N_REQ: per-requester end of message
- `s_axis_tready_o` out N_REQ: per-requester ready
- `m_axis_tdata_o` out 8: byte to the UART
- `m_axis_tvalid_o` out 1: valid to the UART
- `m_axis_tlast_o` out 1: last byte of the current grant
- `m_axis_tready_i` in 1: UART ready, high only in UART IDLE
- `grant_o` out N_REQ: one-hot current owner, 0 when idle
- `busy_o` out 1: high in state GRANT

## Operation
- States: IDLE, GRANT.
- Registers: `grant` (one-hot), `last_ptr` (index of previous winner), `beat_cnt` (width log2(MAX_BURST)).
- IDLE: all `s_axis_tready_o`=0, `m_axis_tvalid_o`=0. If any `s_axis_tvalid_i` bit is set, select the first set bit searching upward from `last_ptr`+1, wrapping modulo N_REQ. Register `grant`, clear `beat_cnt`, go to GRANT.
- GRANT, owner g: `m_axis_tdata_o`=tdata[g]; `m_axis_tvalid_o`=tvalid[g]; `s_axis_tready_o[g]`=`m_axis_tready_i`; all other readies are 0.
- Handshake is `m_axis_tvalid_o` & `m_axis_tready_i`. On a handshake, `beat_cnt`++.
- `m_axis_tlast_o` = tlast[g] | (`beat_cnt`==MAX_BURST-1), qualified by GRANT.
- A handshake with `m_axis_tlast_o`=1 releases the grant: `last_ptr`<=g, `grant`<=0, next state IDLE.
- If tvalid[g] drops mid-message, the grant is held indefinitely. There is no timeout.
- Non-owner valids are ignored until re-arbitration and are never acknowledged.
- Arithmetic: the `beat_cnt` comparison uses the full counter width. MAX_BURST=256 wraps naturally at 8 bits, but release happens at 255 first.

## Timing
- Reset values: `grant`=0, `grant_o`=0, `busy_o`=0, `last_ptr`=N_REQ-1 (so requester 0 wins first), `beat_cnt`=0, state IDLE. All outputs are 0 during reset.
- Arbitration latency: 1 cycle. A request seen in IDLE at cycle t puts the owner's data on `m_axis_*` at cycle t+1.
- Data path is combinational from the granted requester, with 0 added latency. tready is a combinational pass-through of `m_axis_tready_i`.
- After release, exactly 1 IDLE bubble cycle occurs before the next grant. The same requester may win again only if no other requester is valid.
- Simultaneous events:
  - Release and new requests in the same cycle: the new requests are arbitrated in the following IDLE cycle using the updated `last_ptr`.
  - All requesters valid: the grant order is strictly cyclic.
- Reset mid-message: the grant drops asynchronously, tready and tvalid go to 0 immediately, and the partially sent message is abandoned.

## Structure
- Shared package `uart_pkg`:
  - `arb_state_t` enum {IDLE, GRANT}
  - localparam `UART_DATA_W`=8
- Sub-module `rr_pick`: purely combinational. Inputs are the request vector and `last_ptr`; outputs are the one-hot winner and its index. It is the only natural split.
- Output muxing and the FSM live in the top module.

## Test plan
- After reset, requesters 0 and 2 both valid, each with a 3-byte message (0x41,0x42,0x43 with tlast on 0x43 / 0x61,0x62,0x63) -> UART receives 41 42 43, then 1 idle cycle, then 61 62 63. `grant_o` sequence is 0001 then 0100.
- Requester 1 streams 40 bytes with no tlast, MAX_BURST=16, requester 3 also valid -> 16 bytes from 1 with `m_axis_tlast_o` on the 16th, then requester 3's message, then the next 16 bytes from 1.
- `m_axis_tready_i` held low 5 cycles mid-message -> `s_axis_tready_o[g]` stays 0, no beats lost or duplicated, `beat_cnt` unchanged.
- All 4 requesters continuously valid with 1-byte messages -> grant order 0,1,2,3,0,1 and each requester receives exactly one handshake per round.
- `rst_i` asserted between byte 2 and byte 3 of a message -> `grant_o`=0 and `m_axis_tvalid_o`=0 in the same cycle. After release, requester 0 wins first again.
- Owner drops tvalid for 10 cycles mid-message while requester 2 is valid -> grant stays on the owner, `s_axis_tready_o[2]`=0 throughout, and the message resumes intact.
